// File: rtl/apb_mem_pkg.sv
// ---------------------------------------------------------------------------
// apb_mem_pkg
// Shared types and helpers for the APB memory target slice.
//   mem_state_t : controller states (IDLE, WAIT, RESP)
//   mem_rsp_t   : pending response kind carried from decode to RESP
//   word_index  : byte address -> word index relative to a base address
//   sat_inc16   : 16-bit saturating increment used by the access counters
// ---------------------------------------------------------------------------
package apb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_state_t;

   typedef enum logic [1:0] {
      RSP_OK,
      RSP_BADACC,
      RSP_BADADDR
   } mem_rsp_t;

   // The operands are zero-extended to 64 bits by the caller. The result is
   // only meaningful when addr >= base; callers flag addr < base separately,
   // so a wrapped difference can never be mistaken for an in-range index.
   function automatic logic [63:0] word_index(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input int          byte_shift);
      return (addr - base) >> byte_shift;
   endfunction

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/apb_mem_array.sv
// ---------------------------------------------------------------------------
// apb_mem_array
// Single-port synchronous RAM, MEM_DEPTH words of DATA_WIDTH bits.
// The read port registers mem[addr] on every clock, so read data is valid
// one cycle after the address is presented (read-before-write on a
// same-address write). Contents are never reset.
// Ports:
//   PCLK   in   clock
//   we     in   write enable
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module apb_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int IDX_WIDTH  = 8
) (
   input  logic                  PCLK,
   input  logic                  we,
   input  logic [IDX_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Storage and read register. The read happens every cycle; the controller
   // decides when rdata is actually consumed, which keeps the array trivial.
   always_ff @(posedge PCLK) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/apb_mem_target.sv
// ---------------------------------------------------------------------------
// apb_mem_target
// Memory target sitting behind the APB-to-memory bridge. Decodes each
// read/write strobe, checks range, alignment and the read-only low region,
// waits WAIT_STATES cycles for good accesses and returns a one-cycle
// completion or error pulse.
// Ports:
//   PCLK             in   clock
//   PRESETn          in   synchronous reset, active HIGH despite the name
//   read, write      in   one-cycle strobes (both at once is an error)
//   address          in   byte address, valid in the strobe cycle
//   write_data       in   write data, sampled at the end of the wait phase
//   read_data        out  last successful read, held until the next one
//   access_complete  out  pulse, access succeeded
//   invalid_access   out  pulse, read-only write or read+write together
//   invalid_address  out  pulse, out of range or misaligned
// Optional (macro APB_MEM_TARGET_CNT_EN):
//   rd_count, wr_count, err_count  out  16-bit saturating event counters
// ---------------------------------------------------------------------------
module apb_mem_target
   import apb_mem_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEM_DEPTH   = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 2,
   parameter int                    RO_WORDS    = 4
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  access_complete,
   output logic                  invalid_access,
   output logic                  invalid_address
`ifdef APB_MEM_TARGET_CNT_EN
   ,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count,
   output logic [15:0]           err_count
`endif
);

   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int WCNT_WIDTH = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [WCNT_WIDTH-1:0] WAIT_INIT  = WCNT_WIDTH'(WAIT_STATES - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << BYTE_SHIFT) - 64'd1);

   mem_state_t            state;
   mem_rsp_t              rsp_q;
   logic                  op_read_q;
   logic [IDX_WIDTH-1:0]  idx_q;
   logic [WCNT_WIDTH-1:0] wait_cnt;
   logic [DATA_WIDTH-1:0] read_data_q;

   logic [ADDR_WIDTH-1:0] offset;
   logic [63:0]           index_full;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Address decode of the incoming strobe. The byte offset is kept at
   // ADDR_WIDTH bits for the alignment test; the index is compared at full
   // width so an oversized offset can never alias back into the array.
   assign offset       = address - BASE_ADDR;
   assign index_full   = word_index(64'(address), 64'(BASE_ADDR), BYTE_SHIFT);
   assign misaligned   = (offset & ALIGN_MASK) != '0;
   assign out_of_range = (address < BASE_ADDR) || (index_full >= 64'(MEM_DEPTH));

   // The RAM is written on the last wait cycle, which is also when write_data
   // is sampled. Reset gates the strobe so an aborted write leaves no trace.
   assign ram_we = (state == WAIT) && (wait_cnt == '0) && !op_read_q && !PRESETn;

   apb_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_array (
      .PCLK  (PCLK),
      .we    (ram_we),
      .addr  (idx_q),
      .wdata (write_data),
      .rdata (ram_rdata)
   );

   // The RAM's registered output is live during the RESP cycle of a read, so
   // it is forwarded there; read_data_q captures it for the following cycles.
   assign read_data = (access_complete && op_read_q) ? ram_rdata : read_data_q;

   // Controller: decode in IDLE, count down in WAIT, pulse in RESP. The
   // response pulse is registered on entry to RESP so it is visible for
   // exactly the RESP cycle. Strobes outside IDLE are simply not looked at.
   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         state           <= IDLE;
         rsp_q           <= RSP_OK;
         op_read_q       <= 1'b0;
         idx_q           <= '0;
         wait_cnt        <= '0;
         read_data_q     <= '0;
         access_complete <= 1'b0;
         invalid_access  <= 1'b0;
         invalid_address <= 1'b0;
      end else begin
         access_complete <= 1'b0;
         invalid_access  <= 1'b0;
         invalid_address <= 1'b0;
         case (state)
            IDLE: begin
               if (read || write) begin
                  op_read_q <= read;
                  idx_q     <= index_full[IDX_WIDTH-1:0];
                  if (misaligned || out_of_range) begin
                     rsp_q           <= RSP_BADADDR;
                     invalid_address <= 1'b1;
                     state           <= RESP;
                  end else if (read && write) begin
                     rsp_q          <= RSP_BADACC;
                     invalid_access <= 1'b1;
                     state          <= RESP;
                  end else if (write && (index_full < 64'(RO_WORDS))) begin
                     rsp_q          <= RSP_BADACC;
                     invalid_access <= 1'b1;
                     state          <= RESP;
                  end else begin
                     rsp_q    <= RSP_OK;
                     wait_cnt <= WAIT_INIT;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  access_complete <= 1'b1;
                  state           <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if ((rsp_q == RSP_OK) && op_read_q) begin
                  read_data_q <= ram_rdata;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef APB_MEM_TARGET_CNT_EN
   // Event counters advance on the RESP cycle, so each reflects a response
   // one cycle after its pulse. A reset during RESP wins and clears them.
   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else if (state == RESP) begin
         if (rsp_q != RSP_OK) begin
            err_count <= sat_inc16(err_count);
         end else if (op_read_q) begin
            rd_count <= sat_inc16(rd_count);
         end else begin
            wr_count <= sat_inc16(wr_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_apb_mem_target.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_apb_mem_target
// Directed bench for apb_mem_target with a cycle-level reference model.
// Honours APB_MEM_TARGET_CNT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_apb_mem_target;

   localparam int          DW    = 32;
   localparam int          AW    = 32;
   localparam int          DEPTH = 256;
   localparam int          WS    = 2;
   localparam int          RO    = 4;
   localparam logic [31:0] BASE  = 32'h0;

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_ACC  = 2;
   localparam int K_ADDR = 3;

   logic          PCLK;
   logic          PRESETn;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic          access_complete;
   logic          invalid_access;
   logic          invalid_address;
`ifdef APB_MEM_TARGET_CNT_EN
   logic [15:0]   rd_count;
   logic [15:0]   wr_count;
   logic [15:0]   err_count;
`endif

   int checks   = 0;
   int failures = 0;

   apb_mem_target #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .MEM_DEPTH   (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_STATES (WS),
      .RO_WORDS    (RO)
   ) dut (
      .PCLK            (PCLK),
      .PRESETn         (PRESETn),
      .read            (read),
      .write           (write),
      .address         (address),
      .write_data      (write_data),
      .read_data       (read_data),
      .access_complete (access_complete),
      .invalid_access  (invalid_access),
      .invalid_address (invalid_address)
`ifdef APB_MEM_TARGET_CNT_EN
      ,
      .rd_count        (rd_count),
      .wr_count        (wr_count),
      .err_count       (err_count)
`endif
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Shared comparison helper for the model process and literal checks.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // One-cycle strobe; write_data carries junk in the strobe cycle and the
   // real value from the next cycle on. Returns inside the cycle after the
   // strobe, before its falling edge.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge PCLK); #1;
      read       = rd;
      write      = wr;
      address    = addr;
      write_data = 32'h0BAD_0BAD;
      @(posedge PCLK); #1;
      read       = 1'b0;
      write      = 1'b0;
      address    = 32'hFFFF_FFF0;
      write_data = wdata;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] model_mem   [DEPTH];
   bit          model_known [DEPTH];
   bit          pend_valid = 0;
   int          pend_cycle;
   int          pend_kind;
   int          pend_idx;
   logic [31:0] pend_data;
   logic [31:0] exp_rd = 32'h0;
   int          cyc    = 0;
   bit          armed  = 0;
   int          exp_rdc  = 0;
   int          exp_wrc  = 0;
   int          exp_errc = 0;

   always @(negedge PCLK) begin : model
      bit          e_ac, e_ia, e_iad, resp_now, skip_rd;
      logic [31:0] e_rd;
      longint      off;
      int          kind, idx;
      e_ac = 0; e_ia = 0; e_iad = 0; resp_now = 0; skip_rd = 0;
      e_rd = exp_rd;
      kind = K_RD; idx = 0; off = 0;

      if (pend_valid && pend_cycle == cyc) begin
         resp_now   = 1;
         pend_valid = 0;
         case (pend_kind)
            K_RD: begin
               e_ac = 1;
               if (model_known[pend_idx]) begin
                  e_rd = model_mem[pend_idx];
               end else begin
                  model_mem[pend_idx]   = read_data;
                  model_known[pend_idx] = 1;
                  e_rd    = read_data;
                  skip_rd = 1;
               end
            end
            K_WR: begin
               e_ac = 1;
               model_mem[pend_idx]   = pend_data;
               model_known[pend_idx] = 1;
            end
            K_ACC:   e_ia  = 1;
            default: e_iad = 1;
         endcase
      end

      if (armed) begin
         checkOutput("model_access_complete", {31'b0, access_complete}, {31'b0, e_ac});
         checkOutput("model_invalid_access", {31'b0, invalid_access}, {31'b0, e_ia});
         checkOutput("model_invalid_address", {31'b0, invalid_address}, {31'b0, e_iad});
         if (!skip_rd) checkOutput("model_read_data", read_data, e_rd);
`ifdef APB_MEM_TARGET_CNT_EN
         checkOutput("model_rd_count", {16'b0, rd_count}, exp_rdc);
         checkOutput("model_wr_count", {16'b0, wr_count}, exp_wrc);
         checkOutput("model_err_count", {16'b0, err_count}, exp_errc);
`endif
      end

      if (resp_now) begin
         if (pend_kind == K_RD) begin
            exp_rd = e_rd;
            if (exp_rdc < 65535) exp_rdc++;
         end else if (pend_kind == K_WR) begin
            if (exp_wrc < 65535) exp_wrc++;
         end else begin
            if (exp_errc < 65535) exp_errc++;
         end
      end

      if (PRESETn) begin
         pend_valid = 0;
         exp_rd     = 32'h0;
         exp_rdc    = 0;
         exp_wrc    = 0;
         exp_errc   = 0;
         armed      = 1;
      end else if (!resp_now && !pend_valid && (read || write)) begin
         if (address < BASE) begin
            kind = K_ADDR;
         end else begin
            off = longint'(address) - longint'(BASE);
            idx = int'(off / 4);
            if ((off % 4) != 0 || off / 4 >= DEPTH) kind = K_ADDR;
            else if (read && write)                  kind = K_ACC;
            else if (write && idx < RO)              kind = K_ACC;
            else                                     kind = read ? K_RD : K_WR;
         end
         pend_valid = 1;
         pend_kind  = kind;
         pend_idx   = idx;
         pend_cycle = (kind == K_RD || kind == K_WR) ? cyc + WS + 1 : cyc + 1;
      end

      if (pend_valid && pend_kind == K_WR && cyc == pend_cycle - 1) begin
         pend_data = write_data;
      end
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      PRESETn    = 1'b1;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      write_data = '0;
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b0;
      @(negedge PCLK);
      checkOutput("reset_access_complete", {31'b0, access_complete}, 32'h0);
      checkOutput("reset_invalid_access", {31'b0, invalid_access}, 32'h0);
      checkOutput("reset_invalid_address", {31'b0, invalid_address}, 32'h0);
      checkOutput("reset_read_data", read_data, 32'h0);

      applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
      repeat (2) @(negedge PCLK);
      checkOutput("wr40_not_early", {31'b0, access_complete}, 32'h0);
      @(negedge PCLK);
      checkOutput("wr40_complete", {31'b0, access_complete}, 32'h1);

      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
      repeat (3) @(negedge PCLK);
      checkOutput("rd40_complete", {31'b0, access_complete}, 32'h1);
      checkOutput("rd40_data", read_data, 32'hDEAD_BEEF);

      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0);
      @(negedge PCLK);
      checkOutput("oor_invalid_address", {31'b0, invalid_address}, 32'h1);
      checkOutput("oor_no_invalid_access", {31'b0, invalid_access}, 32'h0);

      applyStimulus(1'b1, 1'b0, 32'h41, 32'h0);
      @(negedge PCLK);
      checkOutput("misaligned_invalid_address", {31'b0, invalid_address}, 32'h1);
      checkOutput("misaligned_read_data_held", read_data, 32'hDEAD_BEEF);

      applyStimulus(1'b1, 1'b0, 32'h04, 32'h0);
      repeat (3) @(negedge PCLK);

      applyStimulus(1'b0, 1'b1, 32'h04, 32'h1234_5678);
      @(negedge PCLK);
      checkOutput("ro_invalid_access", {31'b0, invalid_access}, 32'h1);
      checkOutput("ro_no_complete", {31'b0, access_complete}, 32'h0);

      applyStimulus(1'b1, 1'b0, 32'h04, 32'h0);
      repeat (3) @(negedge PCLK);

      applyStimulus(1'b1, 1'b1, 32'h10, 32'h0);
      @(negedge PCLK);
      checkOutput("rw_invalid_access", {31'b0, invalid_access}, 32'h1);
      checkOutput("rw_no_invalid_address", {31'b0, invalid_address}, 32'h0);

      // Read 0x40 with a write strobe to 0x44 landing in the wait phase.
      @(posedge PCLK); #1;
      read = 1'b1; address = 32'h40;
      @(posedge PCLK); #1;
      read = 1'b0; write = 1'b1; address = 32'h44; write_data = 32'h5555_5555;
      @(posedge PCLK); #1;
      write = 1'b0;
      repeat (2) @(negedge PCLK);
      checkOutput("busy_first_complete", {31'b0, access_complete}, 32'h1);
      @(negedge PCLK);
      checkOutput("busy_second_ignored", {31'b0, access_complete}, 32'h0);

      // Write 0x40 aborted by a reset in the middle of the wait phase.
      @(posedge PCLK); #1;
      write = 1'b1; address = 32'h40; write_data = 32'h0BAD_0BAD;
      @(posedge PCLK); #1;
      write = 1'b0; write_data = 32'hCAFE_F00D; PRESETn = 1'b1;
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      @(negedge PCLK);
      checkOutput("rst_mid_access_complete", {31'b0, access_complete}, 32'h0);
      checkOutput("rst_mid_invalid_access", {31'b0, invalid_access}, 32'h0);
      checkOutput("rst_mid_invalid_address", {31'b0, invalid_address}, 32'h0);
      checkOutput("rst_mid_read_data", read_data, 32'h0);
      @(negedge PCLK);
      checkOutput("rst_mid_no_pulse", {31'b0, access_complete}, 32'h0);

      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
      repeat (3) @(negedge PCLK);
      checkOutput("rst_mem_kept", read_data, 32'hDEAD_BEEF);

      // Since the reset: 1 read above, then 1 read, 1 write, 3 errors.
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
      repeat (3) @(negedge PCLK);
      applyStimulus(1'b0, 1'b1, 32'h80, 32'hA5A5_A5A5);
      repeat (3) @(negedge PCLK);
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0);
      @(negedge PCLK);
      applyStimulus(1'b0, 1'b1, 32'h00, 32'h7777_7777);
      @(negedge PCLK);
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h0);
      @(negedge PCLK);
      applyStimulus(1'b1, 1'b0, 32'h80, 32'h0);
      repeat (3) @(negedge PCLK);
      checkOutput("rd80_data", read_data, 32'hA5A5_A5A5);
      repeat (2) @(negedge PCLK);
`ifdef APB_MEM_TARGET_CNT_EN
      checkOutput("cnt_rd", {16'b0, rd_count}, 32'd3);
      checkOutput("cnt_wr", {16'b0, wr_count}, 32'd1);
      checkOutput("cnt_err", {16'b0, err_count}, 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
